// File: rtl/vm80_intc.sv
// Priority interrupt controller for the vm80a CPU system.
// Latches rising edges on eight peripheral sources, masks and prioritises them
// (level 0 highest), drives the CPU INT pin and answers the 8080 INTA cycle
// with an RST opcode. In-service levels are tracked for fully nested operation.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   irq[7:0]          rising-edge interrupt sources, synchronous to clk
//   cs, wr, adr, din  register access (0 IRR, 1 IMR, 2 ISR/EOI, 3 STAT)
//   dout[7:0]         register read data, or the RST vector during INTA
//   sync, stat_inta   CPU status strobe and INTA status bit
//   dbin              CPU data bus read strobe; its falling edge ends INTA
//   vec_oe            high while an INTA cycle is active
//   int_req           to CPU INT pin
module vm80_intc #(
  parameter bit         AUTO_EOI = 1'b0,
  parameter logic [7:0] RST_BASE = 8'hC7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic       cs,
  input  logic       wr,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       sync,
  input  logic       stat_inta,
  input  logic       dbin,
  output logic       vec_oe,
  output logic       int_req
);

  localparam int unsigned NLVL = 8;
  localparam int unsigned LW   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [NLVL-1:0] irr, imr, isr, irq_d;
  logic [NLVL-1:0] irr_n, imr_n, isr_n;
  logic [7:0]      vec_q;
  logic [LW-1:0]   ack_lvl;
  logic            ack_valid;
  logic            dbin_d;

  logic [NLVL-1:0] irq_rise, pend;
  logic [LW-1:0]   pend_lvl, isr_lvl;
  logic            pend_valid, reg_wr, take, ack_fire;
  logic [7:0]      reg_rd;

  // Index of the lowest set bit (0 when empty; callers qualify with |v).
  function automatic logic [LW-1:0] low_bit(input logic [NLVL-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    for (int i = NLVL - 1; i >= 0; i--)
      if (v[i]) r = LW'(i);
    return r;
  endfunction

  // Priority resolution against the highest in-service level.
  always_comb begin
    irq_rise   = irq & ~irq_d;
    pend       = irr & ~imr;
    pend_lvl   = low_bit(pend);
    isr_lvl    = low_bit(isr);
    pend_valid = (|pend) && ((isr == '0) || (pend_lvl < isr_lvl));
    reg_wr     = cs & wr;
    take       = (state_q == ST_IDLE) & sync & stat_inta;
    ack_fire   = (state_q == ST_ACK) & dbin_d & ~dbin;
  end

  // INTA sequencer next state; extra sync pulses during ACK are ignored.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (sync && stat_inta) state_n = ST_ACK;
      ST_ACK:  if (ack_fire)          state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Register next values; new edges are applied last so a set beats any clear,
  // and EOI looks at the old ISR before the acknowledged level is marked.
  always_comb begin
    irr_n = irr;
    imr_n = imr;
    isr_n = isr;
    if (reg_wr && adr == 2'd0) irr_n = irr_n & ~din;
    if (reg_wr && adr == 2'd1) imr_n = din;
    if (reg_wr && adr == 2'd2 && (isr != '0)) isr_n[isr_lvl] = 1'b0;
    if (ack_fire && ack_valid) begin
      irr_n[ack_lvl] = 1'b0;
      if (!AUTO_EOI) isr_n[ack_lvl] = 1'b1;
    end
    irr_n = irr_n | irq_rise;
  end

  // State and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irr       <= '0;
      imr       <= '1;
      isr       <= '0;
      irq_d     <= '0;
      dbin_d    <= 1'b0;
      int_req   <= 1'b0;
      vec_q     <= 8'hFF;
      ack_lvl   <= '0;
      ack_valid <= 1'b0;
    end else begin
      state_q <= state_n;
      irr     <= irr_n;
      imr     <= imr_n;
      isr     <= isr_n;
      irq_d   <= irq;
      dbin_d  <= dbin;
      int_req <= pend_valid & ~vec_oe;
      if (take) begin
        // No winner at sync time answers with RST 7 (spurious).
        vec_q     <= pend_valid ? (RST_BASE | 8'({pend_lvl, 3'b000})) : 8'hFF;
        ack_lvl   <= pend_lvl;
        ack_valid <= pend_valid;
      end
    end
  end

  assign vec_oe = (state_q == ST_ACK);

  // Read mux; the latched vector overrides it during INTA.
  always_comb begin
    reg_rd = irr;
    case (adr)
      2'd0: reg_rd = irr;
      2'd1: reg_rd = imr;
      2'd2: reg_rd = isr;
      2'd3: reg_rd = {vec_oe, 3'b000, pend_valid, pend_lvl};
      default: reg_rd = irr;
    endcase
    dout = vec_oe ? vec_q : reg_rd;
  end

endmodule

// File: tb/tb_vm80_intc.sv
// Self-checking bench for vm80_intc: a vector table (inputs + expected
// dout/int_req/vec_oe) run through a scoreboard queue, plus hand-written
// sequences for reset, AUTO_EOI and reset during INTA.
module tb_vm80_intc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic       cs, wr;
  logic [1:0] adr;
  logic [7:0] din;
  logic       sync, stat_inta, dbin;
  logic [7:0] dout, dout1;
  logic       vec_oe, vec_oe1, int_req, int_req1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vm80_intc #(.AUTO_EOI(1'b0), .RST_BASE(8'hC7)) u0 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .cs(cs), .wr(wr), .adr(adr),
    .din(din), .dout(dout), .sync(sync), .stat_inta(stat_inta),
    .dbin(dbin), .vec_oe(vec_oe), .int_req(int_req)
  );

  vm80_intc #(.AUTO_EOI(1'b1), .RST_BASE(8'hC7)) u1 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .cs(cs), .wr(wr), .adr(adr),
    .din(din), .dout(dout1), .sync(sync), .stat_inta(stat_inta),
    .dbin(dbin), .vec_oe(vec_oe1), .int_req(int_req1)
  );

  typedef struct {
    logic       cs, wr;
    logic [1:0] adr;
    logic [7:0] din, irq;
    logic       sync, inta, dbin, chk;
    logic [7:0] e_dout;
    logic       e_int, e_voe;
  } vec_t;

  typedef struct {
    int         idx;
    logic [9:0] e;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  task automatic add(input logic c, input logic w, input logic [1:0] a,
                     input logic [7:0] d, input logic [7:0] q,
                     input logic s, input logic ia, input logic db,
                     input logic ck, input logic [7:0] ed,
                     input logic ei, input logic ev);
    vec_t v;
    v.cs = c; v.wr = w; v.adr = a; v.din = d; v.irq = q;
    v.sync = s; v.inta = ia; v.dbin = db; v.chk = ck;
    v.e_dout = ed; v.e_int = ei; v.e_voe = ev;
    tbl.push_back(v);
  endtask

  task automatic chk8(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; cs = 0; wr = 0; adr = '0; din = '0;
    sync = 0; stat_inta = 0; dbin = 0;

    //   cs wr adr din    irq    sy ia db ck  dout  int voe
    // Level 0 basic request and acknowledge
    add(1, 1, 1, 8'hFE, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 8'h01, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h01, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hC7, 1, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hC7, 0, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h01, 0, 0);
    // Two simultaneous sources, nesting blocks the lower one until EOI
    add(1, 1, 2, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 8'h24, 0, 0, 0, 1, 8'h24, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h24, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hD7, 1, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hD7, 0, 1);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h04, 0, 0);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h04, 0, 0);
    add(1, 1, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 3, 8'h00, 8'h00, 0, 0, 0, 1, 8'h0D, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hEF, 1, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hEF, 0, 1);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h20, 0, 0);
    // Preemption of level 5 by level 1
    add(0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 1, 8'h02, 0, 0);
    add(0, 0, 3, 8'h00, 8'h00, 0, 0, 0, 1, 8'h09, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hCF, 1, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hCF, 0, 1);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h22, 0, 0);
    add(1, 1, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h20, 0, 0);
    add(1, 1, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    // Vector frozen at sync despite masking during ACK; then spurious INTA
    add(0, 0, 0, 8'h00, 8'h08, 0, 0, 0, 1, 8'h08, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h08, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hDF, 1, 1);
    add(1, 1, 1, 8'hFF, 8'h00, 0, 0, 1, 1, 8'hDF, 0, 1);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h08, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(1, 1, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hFF, 0, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hFF, 0, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    // Edge set beats CPU clear on the same bit; level 4 acknowledged
    add(0, 0, 0, 8'h00, 8'h10, 0, 0, 0, 1, 8'h10, 0, 0);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0);
    add(1, 1, 0, 8'h10, 8'h10, 0, 0, 0, 1, 8'h10, 0, 0);
    add(1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 0, 3, 8'h00, 8'h00, 0, 0, 0, 1, 8'h0C, 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'hE7, 1, 1);
    add(0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hE7, 0, 1);
    add(0, 0, 2, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10, 0, 0);

    // Reset values while reset is held
    #12;
    chk8("rst_irr", dout, 8'h00);
    chk8("rst_int_req", 8'(int_req), 8'h00);
    chk8("rst_vec_oe", 8'(vec_oe), 8'h00);
    adr = 2'd1; #1;
    chk8("rst_imr", dout, 8'hFF);
    adr = 2'd2; #1;
    chk8("rst_isr", dout, 8'h00);
    @(negedge clk);
    adr = 2'd0;
    rst_n = 1'b1;

    // Table vectors through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t ex;
      @(negedge clk);
      cs = tbl[i].cs; wr = tbl[i].wr; adr = tbl[i].adr; din = tbl[i].din;
      irq = tbl[i].irq; sync = tbl[i].sync; stat_inta = tbl[i].inta;
      dbin = tbl[i].dbin;
      if (tbl[i].chk) begin
        ex.idx = i;
        ex.e   = {tbl[i].e_dout, tbl[i].e_int, tbl[i].e_voe};
        sbq.push_back(ex);
      end
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        n_cmp++;
        if ({dout, int_req, vec_oe} !== ex.e) begin
          n_bad++;
          $display("FAIL vec%0d: dout/int/voe got %02h/%0b/%0b expected %02h/%0b/%0b",
                   ex.idx, dout, int_req, vec_oe, ex.e[9:2], ex.e[1], ex.e[0]);
        end
      end
    end

    // AUTO_EOI instance never marks the acknowledged level in service
    @(negedge clk);
    cs = 0; wr = 0; adr = 2'd2; din = '0; irq = '0;
    sync = 0; stat_inta = 0; dbin = 0;
    @(posedge clk); #1;
    chk8("isr_normal", dout, 8'h10);
    chk8("isr_auto_eoi", dout1, 8'h00);
    adr = 2'd0; #1;
    chk8("irr_auto_eoi", dout1, 8'h00);
    chk8("int_req_auto_eoi", 8'(int_req1), 8'h00);

    // Reset asserted in the middle of an INTA cycle
    @(negedge clk); irq = 8'h01;
    @(negedge clk); irq = 8'h00;
    @(negedge clk); sync = 1; stat_inta = 1; adr = 2'd1;
    @(posedge clk); #1;
    chk8("inta_vec_oe", 8'(vec_oe), 8'h01);
    chk8("inta_int_req", 8'(int_req), 8'h01);
    chk8("inta_vector", dout, 8'hC7);
    #1 rst_n = 1'b0;
    #1;
    chk8("midrst_vec_oe", 8'(vec_oe), 8'h00);
    chk8("midrst_int_req", 8'(int_req), 8'h00);
    chk8("midrst_imr", dout, 8'hFF);
    chk8("midrst_vec_oe_auto", 8'(vec_oe1), 8'h00);
    @(negedge clk);
    sync = 0; stat_inta = 0; adr = 2'd0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
